// File: rtl/scaler_pkg.sv
// scaler_pkg: shared constants, writer-state encoding and helpers for the scaler matrix RAM.
// Revision 1.0
`default_nettype none

package scaler_pkg;

  localparam int DEF_KERNEL_MAX   = 4;
  localparam int DEF_MATRIX_DELAY = 2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LINE = 2'd1,
    W_WAIT = 2'd2
  } wr_state_t;

  function automatic int CLOG2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scaler_line_ram.sv
// scaler_line_ram: simple dual-port line buffer with one-cycle registered read.
// Revision 1.0
`default_nettype none

module scaler_line_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/scaler_matrix_ram.sv
// scaler_matrix_ram: ring of line buffers feeding a KERNEL_MAX x KERNEL_MAX pixel window.
// Revision 1.0
`default_nettype none

module scaler_matrix_ram
  import scaler_pkg::*;
#(
  parameter int PIXEL_BITWIDTH = 8,
  parameter int IMG_H_BITWIDTH = 13,
  parameter int KERNEL_MAX     = DEF_KERNEL_MAX,
  parameter int MATRIX_DELAY   = DEF_MATRIX_DELAY
) (
  input  logic                                             core_clk,
  input  logic                                             core_rst_n,
  input  logic [IMG_H_BITWIDTH-1:0]                        core_arg_img_src_h,
  input  logic                                             v_start,
  input  logic                                             s_axis_valid,
  output logic                                             s_axis_ready,
  input  logic [PIXEL_BITWIDTH-1:0]                        s_axis_pixel,
  output logic                                             matrix_ram_line_ready,
  input  logic                                             matrix_ram_read_en,
  input  logic                                             matrix_ram_read_done,
  input  logic                                             matrix_ram_read_stride,
  input  logic                                             matrix_ram_read_repeat,
  output logic                                             matrix_ram_read_rsp_en,
  output logic [PIXEL_BITWIDTH*KERNEL_MAX*KERNEL_MAX-1:0]  matrix_ram_read_rsp_pixel
);

  localparam int NBUF  = KERNEL_MAX + 1;
  localparam int BUF_W = CLOG2(NBUF);
  localparam int ROW_W = PIXEL_BITWIDTH * KERNEL_MAX;
  localparam logic [BUF_W-1:0] K_LAST = BUF_W'(KERNEL_MAX);

  wr_state_t                 state, state_nxt;
  logic [BUF_W-1:0]          wr_buf, base, lines_valid, p1_base;
  logic [IMG_H_BITWIDTH-1:0] wr_col, rd_col, last_col;
  logic                      rd_first, p1_first;
  logic [MATRIX_DELAY-1:0]   vld_pipe;
  logic                      accept, line_done, release_line, rd_fire;
  logic [PIXEL_BITWIDTH-1:0] ram_q   [NBUF];
  logic [PIXEL_BITWIDTH-1:0] col_new [KERNEL_MAX];
  logic [PIXEL_BITWIDTH*KERNEL_MAX*KERNEL_MAX-1:0] win_nxt;

  function automatic logic [BUF_W-1:0] ring_next(input logic [BUF_W-1:0] idx);
    return (idx == K_LAST) ? '0 : idx + 1'b1;
  endfunction

  assign last_col              = core_arg_img_src_h - 1'b1;
  assign s_axis_ready          = (state == W_LINE);
  assign accept                = s_axis_valid & s_axis_ready;
  assign line_done             = accept & (wr_col == last_col);
  assign matrix_ram_line_ready = (lines_valid == K_LAST);
  assign rd_fire               = matrix_ram_read_en & matrix_ram_line_ready;
  assign release_line          = matrix_ram_read_done & matrix_ram_read_stride &
                                 ~matrix_ram_read_repeat & (lines_valid != '0);
  assign matrix_ram_read_rsp_en = vld_pipe[MATRIX_DELAY-1];

  always_comb begin
    state_nxt = state;
    case (state)
      W_IDLE:  state_nxt = W_IDLE;
      W_LINE:  if (line_done && lines_valid == K_LAST && !release_line) state_nxt = W_WAIT;
      W_WAIT:  if (release_line) state_nxt = W_LINE;
      default: state_nxt = W_IDLE;
    endcase
    if (v_start) state_nxt = W_LINE;
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) state <= W_IDLE;
    else             state <= state_nxt;
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      wr_buf      <= '0;
      base        <= '0;
      lines_valid <= '0;
      wr_col      <= '0;
      rd_col      <= '0;
      rd_first    <= 1'b1;
      vld_pipe    <= '0;
      p1_base     <= '0;
      p1_first    <= 1'b0;
    end else if (v_start) begin
      wr_buf      <= '0;
      base        <= '0;
      lines_valid <= '0;
      wr_col      <= '0;
      rd_col      <= '0;
      rd_first    <= 1'b1;
      vld_pipe    <= '0;
    end else begin
      if (accept) wr_col <= line_done ? '0 : wr_col + 1'b1;
      if (line_done) wr_buf <= ring_next(wr_buf);
      if (release_line) base <= ring_next(base);
      // A line held in W_WAIT takes over the released slot, so the count is unchanged there.
      if (state != W_WAIT) begin
        if (line_done && !release_line && lines_valid != K_LAST) lines_valid <= lines_valid + 1'b1;
        else if (!line_done && release_line)                     lines_valid <= lines_valid - 1'b1;
      end
      if (matrix_ram_read_done) begin
        rd_col   <= '0;
        rd_first <= 1'b1;
      end else if (rd_fire) begin
        rd_first <= 1'b0;
        if (rd_col != last_col) rd_col <= rd_col + 1'b1;
      end
      vld_pipe <= {vld_pipe[MATRIX_DELAY-2:0], rd_fire};
      p1_base  <= base;
      p1_first <= rd_first;
    end
  end

  for (genvar b = 0; b < NBUF; b++) begin : g_buf
    scaler_line_ram #(
      .DATA_W (PIXEL_BITWIDTH),
      .ADDR_W (IMG_H_BITWIDTH)
    ) u_line_ram (
      .clk     (core_clk),
      .wr_en   (accept && (wr_buf == BUF_W'(b))),
      .wr_addr (wr_col),
      .wr_data (s_axis_pixel),
      .rd_addr (rd_col),
      .rd_data (ram_q[b])
    );
  end

  // Row r of the window comes from buffer (base + r) mod NBUF, using the base seen at read time.
  for (genvar r = 0; r < KERNEL_MAX; r++) begin : g_row
    logic [BUF_W:0] sum;
    assign sum        = {1'b0, p1_base} + (BUF_W+1)'(r);
    assign col_new[r] = (sum > {1'b0, K_LAST}) ? ram_q[BUF_W'(sum - (BUF_W+1)'(NBUF))]
                                               : ram_q[sum[BUF_W-1:0]];
    assign win_nxt[r*ROW_W +: ROW_W] = p1_first ? {KERNEL_MAX{col_new[r]}}
        : {col_new[r], matrix_ram_read_rsp_pixel[r*ROW_W+PIXEL_BITWIDTH +: ROW_W-PIXEL_BITWIDTH]};
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n)                    matrix_ram_read_rsp_pixel <= '0;
    else if (vld_pipe[0] && !v_start)   matrix_ram_read_rsp_pixel <= win_nxt;
  end

endmodule

`default_nettype wire

// File: tb/tb_scaler_matrix_ram.sv
// tb_scaler_matrix_ram: directed scoreboard bench for scaler_matrix_ram.
// Revision 1.0
`default_nettype none

module tb_scaler_matrix_ram;
  import scaler_pkg::*;

  localparam int P = 8;
  localparam int K = 4;
  localparam int H = 8;

  logic          core_clk = 1'b0;
  logic          core_rst_n;
  logic [12:0]   core_arg_img_src_h;
  logic          v_start, s_axis_valid, s_axis_ready;
  logic [P-1:0]  s_axis_pixel;
  logic          matrix_ram_line_ready;
  logic          matrix_ram_read_en, matrix_ram_read_done;
  logic          matrix_ram_read_stride, matrix_ram_read_repeat;
  logic          matrix_ram_read_rsp_en;
  logic [P*K*K-1:0] matrix_ram_read_rsp_pixel;

  int tests = 0;
  int fails = 0;
  int rsp_count = 0;
  logic [P*K*K-1:0] sb [$];

  int m_base, m_rdcol;
  bit m_first;
  int m_cols [K];

  scaler_matrix_ram dut (
    .core_clk                  (core_clk),
    .core_rst_n                (core_rst_n),
    .core_arg_img_src_h        (core_arg_img_src_h),
    .v_start                   (v_start),
    .s_axis_valid              (s_axis_valid),
    .s_axis_ready              (s_axis_ready),
    .s_axis_pixel              (s_axis_pixel),
    .matrix_ram_line_ready     (matrix_ram_line_ready),
    .matrix_ram_read_en        (matrix_ram_read_en),
    .matrix_ram_read_done      (matrix_ram_read_done),
    .matrix_ram_read_stride    (matrix_ram_read_stride),
    .matrix_ram_read_repeat    (matrix_ram_read_repeat),
    .matrix_ram_read_rsp_en    (matrix_ram_read_rsp_en),
    .matrix_ram_read_rsp_pixel (matrix_ram_read_rsp_pixel)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [P-1:0] pix(input int line, input int col);
    return P'((line * 16 + col) & 255);
  endfunction

  task automatic model_read();
    logic [P*K*K-1:0] e;
    if (m_first) begin
      for (int c = 0; c < K; c++) m_cols[c] = m_rdcol;
    end else begin
      for (int c = 0; c < K-1; c++) m_cols[c] = m_cols[c+1];
      m_cols[K-1] = m_rdcol;
    end
    m_first = 0;
    if (m_rdcol < H-1) m_rdcol++;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        e[(r*K+c)*P +: P] = pix(m_base + r, m_cols[c]);
    sb.push_back(e);
  endtask

  always @(negedge core_clk) begin
    if (core_rst_n && matrix_ram_read_rsp_en) begin
      rsp_count++;
      if (sb.size() == 0) check("rsp_spurious", 128'(matrix_ram_read_rsp_en), 128'(0));
      else                check("rsp_window", matrix_ram_read_rsp_pixel, sb.pop_front());
    end
  end

  task automatic send_pixel(input logic [P-1:0] p);
    int  n;
    bit  ok;
    n  = 0;
    ok = 0;
    s_axis_valid = 1'b1;
    s_axis_pixel = p;
    while (!ok && n < 100) begin
      @(negedge core_clk);
      ok = s_axis_ready;
      @(posedge core_clk); #1;
      n++;
    end
    s_axis_valid = 1'b0;
    check("px_accept", 128'(ok), 128'(1));
  endtask

  task automatic send_line(input int line);
    for (int c = 0; c < H; c++) send_pixel(pix(line, c));
  endtask

  task automatic read_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      matrix_ram_read_en = 1'b1;
      model_read();
      @(posedge core_clk); #1;
    end
    matrix_ram_read_en = 1'b0;
  endtask

  task automatic read_done(input bit stride, input bit rep);
    matrix_ram_read_done   = 1'b1;
    matrix_ram_read_stride = stride;
    matrix_ram_read_repeat = rep;
    @(posedge core_clk); #1;
    matrix_ram_read_done   = 1'b0;
    matrix_ram_read_stride = 1'b0;
    matrix_ram_read_repeat = 1'b0;
    m_rdcol = 0;
    m_first = 1;
    if (stride && !rep) m_base++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge core_clk); #1;
      n++;
    end
    check("drain", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    int rsp_base;
    core_rst_n = 1'b0;
    core_arg_img_src_h = 13'(H);
    v_start = 0; s_axis_valid = 0; s_axis_pixel = '0;
    matrix_ram_read_en = 0; matrix_ram_read_done = 0;
    matrix_ram_read_stride = 0; matrix_ram_read_repeat = 0;
    m_base = 0; m_rdcol = 0; m_first = 1;
    for (int c = 0; c < K; c++) m_cols[c] = 0;

    repeat (3) @(posedge core_clk); #1;
    check("rst_ready", 128'(s_axis_ready), 128'(0));
    check("rst_line_ready", 128'(matrix_ram_line_ready), 128'(0));
    check("rst_rsp_en", 128'(matrix_ram_read_rsp_en), 128'(0));
    check("rst_rsp_pixel", matrix_ram_read_rsp_pixel, 128'(0));
    core_rst_n = 1'b1;
    @(posedge core_clk); #1;
    v_start = 1'b1;
    @(posedge core_clk); #1;
    v_start = 1'b0;

    // Fill four lines; line_ready rises right after the 32nd accept.
    for (int l = 0; l < K; l++) begin
      for (int c = 0; c < H; c++) begin
        send_pixel(pix(l, c));
        if (l == K-1 && c == H-2) check("line_ready_early", 128'(matrix_ram_line_ready), 128'(0));
      end
    end
    check("line_ready_fill", 128'(matrix_ram_line_ready), 128'(1));
    check("ready_line5", 128'(s_axis_ready), 128'(1));
    send_line(4);
    repeat (3) @(posedge core_clk); #1;
    check("bp_ready_low", 128'(s_axis_ready), 128'(0));
    check("bp_w_wait", 128'(dut.state), 128'(W_WAIT));

    // Latency and left-border replication.
    matrix_ram_read_en = 1'b1;
    model_read();
    @(posedge core_clk); #1;
    matrix_ram_read_en = 1'b0;
    @(negedge core_clk);
    check("lat_cycle1", 128'(matrix_ram_read_rsp_en), 128'(0));
    @(posedge core_clk); #1;
    @(negedge core_clk);
    check("lat_cycle2", 128'(matrix_ram_read_rsp_en), 128'(1));
    @(posedge core_clk); #1;
    read_cycles(1);
    drain();

    // Repeat keeps the ring, then a back-to-back run hits the right border.
    read_done(1'b0, 1'b1);
    read_cycles(10);
    drain();
    read_done(1'b0, 1'b0);
    read_cycles(2);
    drain();
    check("no_release_ready", 128'(s_axis_ready), 128'(0));

    read_done(1'b1, 1'b0);
    check("stride_ready_back", 128'(s_axis_ready), 128'(1));
    check("stride_line_ready", 128'(matrix_ram_line_ready), 128'(1));
    read_cycles(2);
    drain();

    // Six more strides wrap the five-buffer ring.
    for (int k = 0; k < 6; k++) begin
      send_line(5 + k);
      check("wrap_wait", 128'(s_axis_ready), 128'(0));
      read_done(1'b1, 1'b0);
      read_cycles(2);
      drain();
    end

    // Asynchronous reset mid-line and mid-read.
    for (int c = 0; c < 3; c++) send_pixel(pix(11, c));
    matrix_ram_read_en = 1'b1;
    @(posedge core_clk);
    matrix_ram_read_en = 1'b0;
    #3;
    core_rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_ready", 128'(s_axis_ready), 128'(0));
    check("arst_line_ready", 128'(matrix_ram_line_ready), 128'(0));
    check("arst_rsp_en", 128'(matrix_ram_read_rsp_en), 128'(0));
    check("arst_rsp_pixel", matrix_ram_read_rsp_pixel, 128'(0));
    @(posedge core_clk); #1;
    core_rst_n = 1'b1;
    rsp_base = rsp_count;
    matrix_ram_read_en = 1'b1;
    repeat (4) @(posedge core_clk); #1;
    matrix_ram_read_en = 1'b0;
    repeat (4) @(posedge core_clk); #1;
    check("no_rsp_not_ready", 128'(rsp_count), 128'(rsp_base));
    check("post_rst_line_ready", 128'(matrix_ram_line_ready), 128'(0));
    check("post_rst_ready", 128'(s_axis_ready), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scaler_matrix_ram.md
SCALER_MATRIX_RAM -- requirements
Module: scaler_matrix_ram

Interface
REQ-001 SHALL have parameter PIXEL_BITWIDTH, default 8, bits per pixel.
REQ-002 SHALL have parameter IMG_H_BITWIDTH, default 13, width of line-length and column counters.
REQ-003 SHALL have parameter KERNEL_MAX, default 4, window rows and columns (>= 2).
REQ-004 SHALL have parameter MATRIX_DELAY, default 2, read_en-to-rsp_en latency in cycles (fixed at 2).
REQ-005 SHALL have port core_clk, input, 1, sole clock.
REQ-006 SHALL have port core_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port core_arg_img_src_h, input, IMG_H_BITWIDTH, source pixels per line (>= 1).
REQ-008 SHALL have port v_start, input, 1, frame-start pulse.
REQ-009 SHALL have ports s_axis_valid (input, 1), s_axis_ready (output, 1) and s_axis_pixel (input, PIXEL_BITWIDTH), source pixel stream in raster order.
REQ-010 SHALL have port matrix_ram_line_ready, output, 1, high when KERNEL_MAX complete lines are held.
REQ-011 SHALL have ports matrix_ram_read_en, matrix_ram_read_done, matrix_ram_read_stride and matrix_ram_read_repeat, all input, 1, driven by the scaler LUT.
REQ-012 SHALL have ports matrix_ram_read_rsp_en (output, 1) and matrix_ram_read_rsp_pixel (output, PIXEL_BITWIDTH*KERNEL_MAX*KERNEL_MAX), the window response.

Function
REQ-013 SHALL hold KERNEL_MAX+1 line buffers, each with depth 2^IMG_H_BITWIDTH, used as a ring: KERNEL_MAX read lines plus 1 fill line.
REQ-014 Writer FSM SHALL have states W_IDLE, W_LINE and W_WAIT. W_IDLE goes to W_LINE after v_start. In W_LINE, the last column (core_arg_img_src_h-1) completes the line. If a free buffer exists it stays in W_LINE, else it goes to W_WAIT. W_WAIT goes to W_LINE when a buffer is released.
REQ-015 s_axis_ready SHALL be high only in W_LINE. A pixel is accepted on cycle valid&ready.
REQ-016 lines_valid SHALL increment on each completed line and saturate at KERNEL_MAX. matrix_ram_line_ready = (lines_valid == KERNEL_MAX).
REQ-017 Each matrix_ram_read_en SHALL read column rd_col from all KERNEL_MAX read lines, then increment rd_col.
REQ-018 The read column SHALL shift into a KERNEL_MAX-column window register.
REQ-019 matrix_ram_read_rsp_en SHALL pulse exactly MATRIX_DELAY cycles after each read_en, with back-to-back read_en giving back-to-back rsp_en.
REQ-020 Packing SHALL be pixel[(r*KERNEL_MAX+c)*PIXEL_BITWIDTH +: PIXEL_BITWIDTH]. r=0 is the oldest line and c=0 is the oldest column.
REQ-021 On the first read_en after v_start or read_done, the column read SHALL fill all KERNEL_MAX window columns (left-border replication).
REQ-022 When rd_col reaches core_arg_img_src_h-1 it SHALL hold there (right-border replication).
REQ-023 matrix_ram_read_done SHALL reset rd_col to 0 and sample stride and repeat in the same cycle.
REQ-024 If stride=1 and repeat=0 at done: the oldest read line is released, the ring base advances by 1 with wrap at KERNEL_MAX+1, and lines_valid decrements.
REQ-025 If repeat=1 at done: no line is released (repeat wins over stride).
REQ-026 If both stride and repeat are 0 at done: no line is released.
REQ-027 If a line completes and a release happens in the same cycle, lines_valid SHALL stay unchanged and the writer SHALL continue without entering W_WAIT.
REQ-028 read_en while matrix_ram_line_ready=0 SHALL be ignored: no rsp_en and no rd_col change.
REQ-029 v_start SHALL synchronously clear lines_valid, the ring pointers, the write column, rd_col and the response pipeline, overriding any simultaneous event.

Reset
REQ-030 core_rst_n low SHALL asynchronously force the following: writer FSM to W_IDLE; s_axis_ready, matrix_ram_line_ready and matrix_ram_read_rsp_en to 0; matrix_ram_read_rsp_pixel to 0; all counters and pointers to 0.
REQ-031 Line-buffer contents SHALL NOT be reset.
REQ-032 Reset asserted mid-line SHALL discard the partial line.

Structure
REQ-033 KERNEL_MAX, MATRIX_DELAY, the writer-state encoding and the CLOG2 function SHALL live in the shared scaler package.
REQ-034 One sub-module, scaler_line_ram, SHALL be used: a simple dual-port RAM with 1-cycle read latency, instantiated KERNEL_MAX+1 times.

Verification
REQ-035 Bench SHALL check fill: src_h=8, K=4, v_start, then 4 lines with pixel=line*16+col -> line_ready rises the cycle after the 32nd accept, and s_axis_ready stays high for line 5.
REQ-036 Bench SHALL check latency and replication: read_en at col 0 -> rsp_en 2 cycles later, with row r all columns = r*16+0. A second read_en -> columns {0,0,0,1}.
REQ-037 Bench SHALL check the right edge: 10 read_en on src_h=8 -> the last 3 responses have column 3 = pixel col 7.
REQ-038 Bench SHALL check the stride/repeat ring: done with repeat=1 -> row 0 is still line 0. Done with stride=1 -> row 0 = line 1. 6 strides -> the ring wraps and data stays correct.
REQ-039 Bench SHALL check back-pressure: reads stalled with 5 lines buffered -> writer in W_WAIT and s_axis_ready=0. One stride done -> ready returns next cycle with no pixel lost.
REQ-040 Bench SHALL check async reset mid-line and read_en with line_ready=0: outputs are 0 immediately, and no rsp_en pulse appears.
